// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port word RAM, fixed one-cycle response latency.
// Optional build macro ARB_FIXED_PRIO_EN: master 0 always wins ties (default build is round-robin).
module mem_arbiter #(
    parameter int MEM_SIZE = 1024,
    parameter int AW       = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          m0_valid,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    input  logic [3:0]    m0_wstrb,
    output logic          m0_ready,
    output logic [31:0]   m0_rdata,
    input  logic          m1_valid,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic [3:0]    m1_wstrb,
    output logic          m1_ready,
    output logic [31:0]   m1_rdata,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic          oor_err
);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_SIZE * 4);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        grant_r, grant_nxt_s;
    logic        read_r, read_nxt_s;
    logic        oor_r, oor_nxt_s;
    logic        winner_s;
    logic        win_oor_s;
    logic        resp_s;
    logic [31:0] win_addr_s;
    logic [31:0] win_wdata_s;
    logic [3:0]  win_wstrb_s;
    logic [31:0] resp_data_s;
`ifndef ARB_FIXED_PRIO_EN
    logic        last_grant_r, last_grant_nxt_s;
`endif

    // Winner selection and request mux
    always_comb begin
        if (m0_valid && m1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            winner_s = 1'b0;
`else
            winner_s = ~last_grant_r;
`endif
        end else if (m1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
        win_addr_s  = winner_s ? m1_addr  : m0_addr;
        win_wdata_s = winner_s ? m1_wdata : m0_wdata;
        win_wstrb_s = winner_s ? m1_wstrb : m0_wstrb;
        win_oor_s   = (win_addr_s >= MEM_BYTES);
    end

    // Next-state logic and RAM pin drive (RAM is only touched from IDLE)
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        read_nxt_s       = read_r;
        oor_nxt_s        = oor_r;
`ifndef ARB_FIXED_PRIO_EN
        last_grant_nxt_s = last_grant_r;
`endif
        ram_en           = 1'b0;
        ram_we           = 4'b0000;
        ram_addr         = win_addr_s[AW+1:2];
        ram_wdata        = win_wdata_s;
        case (state_r)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_nxt_s      = RESP;
                    grant_nxt_s      = winner_s;
                    read_nxt_s       = (win_wstrb_s == 4'b0000);
                    oor_nxt_s        = win_oor_s;
`ifndef ARB_FIXED_PRIO_EN
                    last_grant_nxt_s = winner_s;
`endif
                    if (!win_oor_s && resetn) begin
                        ram_en = 1'b1;
                        ram_we = win_wstrb_s;
                    end else begin
                        ram_en = 1'b0;
                        ram_we = 4'b0000;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Response decode; reset held during RESP suppresses the completion
    always_comb begin
        resp_s = (state_r == RESP) && resetn;
        if (resp_s && read_r && !oor_r) begin
            resp_data_s = ram_rdata;
        end else begin
            resp_data_s = 32'h0000_0000;
        end
        m0_ready = resp_s && !grant_r;
        m1_ready = resp_s && grant_r;
        m0_rdata = grant_r ? 32'h0000_0000 : resp_data_s;
        m1_rdata = grant_r ? resp_data_s : 32'h0000_0000;
        oor_err  = resp_s && oor_r;
    end

    // State and transaction registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= IDLE;
            grant_r      <= 1'b0;
            read_r       <= 1'b0;
            oor_r        <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_r <= 1'b1;
`endif
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            read_r       <= read_nxt_s;
            oor_r        <= oor_nxt_s;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_r <= last_grant_nxt_s;
`endif
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port on-chip word memory between two native-bus masters: port 0 is the picorv32 core, port 1 is a loader/debug DMA master.
- Arbitrates between the masters and drives the RAM's enable, byte-write and address pins.
- Returns each master's ready/rdata with a fixed, uniform latency.
- Sits between the masters and the memory array in the system top; peripheral decode stays outside this block.

Parameters:
- MEM_SIZE, 1024, memory depth in 32-bit words; byte addresses at or above MEM_SIZE*4 are out of range.
- AW, 10, memory word-address width; must satisfy 2**AW >= MEM_SIZE.

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- m0_valid  in  1  master 0 request; held until m0_ready
- m0_addr  in  32  master 0 byte address (bits [1:0] ignored)
- m0_wdata  in  32  master 0 write data
- m0_wstrb  in  4  master 0 byte strobes; 0 = read
- m0_ready  out  1  master 0 completion pulse
- m0_rdata  out  32  master 0 read data, valid when m0_ready=1
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same widths and meaning for master 1
- ram_en  out  1  memory access strobe
- ram_we  out  4  byte write enables, qualified by ram_en
- ram_addr  out  AW  word address, addr[AW+1:2]
- ram_wdata  out  32  write data
- ram_rdata  in  32  registered RAM output; valid the cycle after ram_en with ram_we=0
- oor_err  out  1  one-cycle pulse on an out-of-range access

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-low, named resetn; it is sampled on the rising edge of clk.
- Reset values: state=IDLE, last_grant=1 (so master 0 wins the first tie), m0_ready=m1_ready=0, oor_err=0, ram_en=0, ram_we=0. rdata outputs read 0 when not ready.
- FSM states: IDLE, RESP.
- IDLE:
  - If any valid is high, pick a winner. With only one requester, that requester wins. With both, the winner is the master other than last_grant (round-robin).
  - In the same cycle, drive ram_en=1, ram_we=wstrb, ram_addr and ram_wdata from the winner, combinationally from the winner's inputs.
  - If the winner's addr >= MEM_SIZE*4, force ram_en=0 and ram_we=0, and latch oor_flag.
  - Register grant, and set last_grant=winner. Go to RESP.
  - With no request, stay in IDLE with ram_en=0.
- RESP:
  - Assert ready of the granted master only (mx_ready is a decode of state and grant).
  - Reads: rdata=ram_rdata. Writes: rdata=0. Out-of-range accesses: rdata=0, and oor_err=1 in this cycle.
  - Always return to IDLE next cycle. No memory access is issued in RESP.
- Latency: a request seen in IDLE at cycle N gets ready in cycle N+1. Peak throughput is one transfer per 2 cycles.
- Protocol: masters deassert valid, or present a new request, in the cycle after ready. A valid that drops before grant is ignored. A valid that drops during RESP does not abort completion.
- Starvation bound: with both masters permanently requesting, grants alternate 0,1,0,1.
- Reset asserted in RESP: ready is suppressed and the transaction is dropped (a write already issued remains in RAM). The state is IDLE in the first cycle after resetn rises.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: master 0 always wins ties and last_grant is unused. Master 1 is served only in IDLE cycles where m0_valid=0.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single read: preload word 5 = 0x12345678; m0 reads addr 0x14 -> ram_en and ram_addr=5 in cycle N; m0_ready=1 and m0_rdata=0x12345678 in N+1; m1_ready stays 0.
- Byte write: m1 writes addr 0x20, wstrb=4'b0010, wdata=0xAABBCCDD -> ram_we=0010, ram_addr=8; m1_ready in N+1; a subsequent read of word 8 shows only byte 1 = 0xCC changed.
- Contention: m0 and m1 both request continuously after reset for 8 cycles -> grant order m0,m1,m0,m1; four ready pulses, each 2 cycles apart. With ARB_FIXED_PRIO_EN, only m0 is served.
- Out of range: m0 reads addr 0x1000 with MEM_SIZE=1024 -> ram_en stays 0; m0_ready=1, m0_rdata=0 and oor_err=1 in N+1.
- Reset mid-transaction: drive resetn=0 in the RESP cycle -> m0_ready=0 in that cycle; state is IDLE after release; the next tie goes to m0.
- Back-to-back same master: m0 issues a read, then a new read in the cycle after ready -> second ready 2 cycles after the first; no lost or duplicated ready.
